// File: rtl/truth_table_checker_pkg.sv
// Shared FSM state encoding and default geometry for the truth-table checker.
package truth_table_checker_pkg;

    localparam int DEF_IN_W   = 4;
    localparam int DEF_OUT_W  = 2;
    localparam int DEF_SETTLE = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } tt_state_t;

endpackage

// File: rtl/tt_vec_counter.sv
// Stimulus index counter: synchronous clear has priority over enable; last flags the all-ones vector.
// Zero latency on the flag; no backpressure, advances only when enabled.
module tt_vec_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] idx,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (clr)
            idx <= '0;
        else if (en)
            idx <= idx + 1'b1;
    end

    assign last = &idx;

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive sweep of 2**IN_W vectors comparing DUT output against an external ROM; SETTLE+2 cycles per vector, start ignored while busy.
// Build option STOP_ON_ERROR_EN ends the sweep at the first mismatch.
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  exp_addr,
    input  logic [OUT_W-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic             fail_valid,
    output logic [IN_W-1:0]  fail_vec,
    output logic [OUT_W-1:0] fail_got,
    output logic [OUT_W-1:0] fail_exp
);

    localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    tt_state_t       state_q, state_nxt;
    logic [WCW-1:0]  wait_cnt;
    logic [IN_W-1:0] idx;
    logic            last;
    logic            cnt_clr, cnt_en;
    logic            mismatch;
    logic            wait_end;

    tt_vec_counter #(.W(IN_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .idx  (idx),
        .last (last)
    );

    assign mismatch = (dut_out != exp_data);
    assign wait_end = (wait_cnt == WCW'(SETTLE - 1));

    always_comb begin
        state_nxt = state_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = APPLY;
                    cnt_clr   = 1'b1;
                end
            end
            APPLY: state_nxt = WAIT;
            WAIT:  if (wait_end) state_nxt = CHECK;
            CHECK: begin
`ifdef STOP_ON_ERROR_EN
                if (mismatch || last) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                    cnt_en    = 1'b1;
                end
`else
                // The index is never bumped past the final vector so stim holds it in DONE.
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                    cnt_en    = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            wait_cnt <= (state_q == WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else if (cnt_clr) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else if (state_q == CHECK && mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= idx;
                fail_got   <= dut_out;
                fail_exp   <= exp_data;
            end
        end
    end

    assign stim     = idx;
    assign exp_addr = idx;
    assign busy     = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign pass     = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checker instances (SETTLE=1 and SETTLE=3) driving a behavioural DUT and ROM.
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start3;
    logic [3:0] stim, exp_addr, fail_vec, stim3, exp_addr3, fail_vec3;
    logic [1:0] dut_out, exp_data, fail_got, fail_exp;
    logic [1:0] dut_out3, exp_data3, fail_got3, fail_exp3;
    logic       busy, done, pass, fail_valid;
    logic       busy3, done3, pass3, fail_valid3;
    logic [4:0] err_count, err_count3;
    logic [1:0] corr [16];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] model(input logic [3:0] v);
        return {v[3] ^ v[1], (v[2] & v[0]) | v[1]};
    endfunction

    // ROM answers one cycle after the address changes; DUT model is combinational plus an injected xor.
    always_ff @(posedge clk) begin
        exp_data  <= model(exp_addr);
        exp_data3 <= model(exp_addr3);
    end
    assign dut_out  = model(stim) ^ corr[stim];
    assign dut_out3 = model(stim3);

    truth_table_checker #(.IN_W(4), .OUT_W(2), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim), .dut_out(dut_out),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec),
        .fail_got(fail_got), .fail_exp(fail_exp)
    );

    truth_table_checker #(.IN_W(4), .OUT_W(2), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .stim(stim3), .dut_out(dut_out3),
        .exp_addr(exp_addr3), .exp_data(exp_data3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .fail_valid(fail_valid3), .fail_vec(fail_vec3),
        .fail_got(fail_got3), .fail_exp(fail_exp3)
    );

    // Cycle 1 is the edge that samples start; returns -1 if done never arrives.
    task automatic run_sweep(input bit hold, output int cyc, output int regress);
        logic [3:0] prev;
        prev    = 4'd0;
        regress = 0;
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) start = 1'b0;
            if (busy && stim < prev) regress++;
            if (busy) prev = stim;
            if (done) break;
        end
        if (!done) cyc = -1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        for (int i = 0; i < 16; i++) corr[i] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %0b want 0", done); end
        compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL reset_pass: got %0b want 0", pass); end
        compared++; if (err_count !== 5'd0) begin mismatched++; $display("FAIL reset_err: got %0d want 0", err_count); end
        compared++; if (fail_valid !== 1'b0) begin mismatched++; $display("FAIL reset_fail_valid: got %0b want 0", fail_valid); end
        compared++; if (stim !== 4'd0 || exp_addr !== 4'd0) begin mismatched++; $display("FAIL reset_stim: got %0d/%0d want 0/0", stim, exp_addr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pass;
        int cyc, reg_n;
        run_sweep(1'b0, cyc, reg_n);
        compared++; if (cyc !== 49) begin mismatched++; $display("FAIL pass_done_cycle: got %0d want 49", cyc); end
        compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL pass_flag: got %0b want 1", pass); end
        compared++; if (err_count !== 5'd0) begin mismatched++; $display("FAIL pass_err: got %0d want 0", err_count); end
        compared++; if (fail_valid !== 1'b0) begin mismatched++; $display("FAIL pass_fail_valid: got %0b want 0", fail_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL pass_busy_with_done: got %0b want 0", busy); end
        compared++; if (stim !== 4'b1111) begin mismatched++; $display("FAIL pass_stim_hold: got %0d want 15", stim); end
    endtask

    task automatic test_single_error;
        int cyc, reg_n;
        corr[5] = 2'b10;
        run_sweep(1'b0, cyc, reg_n);
`ifdef STOP_ON_ERROR_EN
        compared++; if (cyc !== 19) begin mismatched++; $display("FAIL single_done_cycle: got %0d want 19", cyc); end
        compared++; if (stim !== 4'b0101) begin mismatched++; $display("FAIL single_stim_hold: got %0d want 5", stim); end
`else
        compared++; if (cyc !== 49) begin mismatched++; $display("FAIL single_done_cycle: got %0d want 49", cyc); end
`endif
        compared++; if (err_count !== 5'd1) begin mismatched++; $display("FAIL single_err: got %0d want 1", err_count); end
        compared++; if (fail_vec !== 4'b0101) begin mismatched++; $display("FAIL single_fail_vec: got %0d want 5", fail_vec); end
        compared++; if (fail_got !== 2'b11) begin mismatched++; $display("FAIL single_fail_got: got %0d want 3", fail_got); end
        compared++; if (fail_exp !== 2'b01) begin mismatched++; $display("FAIL single_fail_exp: got %0d want 1", fail_exp); end
        compared++; if (fail_valid !== 1'b1) begin mismatched++; $display("FAIL single_fail_valid: got %0b want 1", fail_valid); end
        compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL single_pass: got %0b want 0", pass); end
    endtask

    task automatic test_double_error;
        int cyc, reg_n;
        corr[5]  = 2'b10;
        corr[12] = 2'b11;
        run_sweep(1'b0, cyc, reg_n);
`ifdef STOP_ON_ERROR_EN
        compared++; if (cyc !== 19) begin mismatched++; $display("FAIL double_done_cycle: got %0d want 19", cyc); end
        compared++; if (err_count !== 5'd1) begin mismatched++; $display("FAIL double_err: got %0d want 1", err_count); end
`else
        compared++; if (cyc !== 49) begin mismatched++; $display("FAIL double_done_cycle: got %0d want 49", cyc); end
        compared++; if (err_count !== 5'd2) begin mismatched++; $display("FAIL double_err: got %0d want 2", err_count); end
`endif
        compared++; if (fail_vec !== 4'b0101) begin mismatched++; $display("FAIL double_fail_vec: got %0d want 5", fail_vec); end
        compared++; if (fail_got !== 2'b11) begin mismatched++; $display("FAIL double_fail_got: got %0d want 3", fail_got); end
        corr[5]  = 2'b00;
        corr[12] = 2'b00;
    endtask

    task automatic test_reset_mid_sweep;
        int cyc, reg_n;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (stim == 4'b0111) begin seen = 1'b1; break; end
        end
        compared++; if (!seen) begin mismatched++; $display("FAIL mid_reach_vec7: got stim %0d want 7", stim); end
        #2 rst = 1'b1;
        #1;
        compared++; if ({busy, done, pass, fail_valid} !== 4'b0000) begin mismatched++; $display("FAIL mid_async_flags: got %b want 0000", {busy, done, pass, fail_valid}); end
        compared++; if (stim !== 4'd0 || exp_addr !== 4'd0 || err_count !== 5'd0) begin mismatched++; $display("FAIL mid_async_regs: got %0d/%0d/%0d want 0/0/0", stim, exp_addr, err_count); end
        compared++; if ({fail_vec, fail_got, fail_exp} !== 8'd0) begin mismatched++; $display("FAIL mid_async_fail: got %h want 0", {fail_vec, fail_got, fail_exp}); end
        @(negedge clk);
        rst = 1'b0;
        run_sweep(1'b0, cyc, reg_n);
        compared++; if (cyc !== 49) begin mismatched++; $display("FAIL mid_restart_cycle: got %0d want 49", cyc); end
        compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL mid_restart_pass: got %0b want 1", pass); end
    endtask

    task automatic test_start_held;
        int cyc, reg_n;
        run_sweep(1'b1, cyc, reg_n);
        compared++; if (cyc !== 49) begin mismatched++; $display("FAIL held_done_cycle: got %0d want 49", cyc); end
        compared++; if (reg_n !== 0) begin mismatched++; $display("FAIL held_restart: got %0d regressions want 0", reg_n); end
        compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL held_pass: got %0b want 1", pass); end
    endtask

    task automatic test_settle3;
        int cyc;
        cyc = 0;
        @(negedge clk);
        start3 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            start3 = 1'b0;
            if (done3) break;
        end
        if (!done3) cyc = -1;
        compared++; if (cyc !== 81) begin mismatched++; $display("FAIL settle3_done_cycle: got %0d want 81", cyc); end
        compared++; if (pass3 !== 1'b1 || err_count3 !== 5'd0) begin mismatched++; $display("FAIL settle3_result: got pass %0b err %0d want 1/0", pass3, err_count3); end
    endtask

    initial begin
        test_reset;
        test_pass;
        test_single_error;
        corr[5] = 2'b00;
        test_double_error;
        test_reset_mid_sweep;
        test_start_held;
        test_settle3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
